spi_master_core_mc: RTL and testbench
=====================================

// Module: spi_master_core_mc
// PURPOSE
//  Parametrised multi-slave SPI master: generalised successor of the fixed 32-bit single-SS SPI control logic.
//  Integrates the SCK divider, all four CPOL/CPHA modes, per-transfer length 1..DATA_WIDTH, MSB/LSB order,
//  NUM_SS one-hot-low selects and a sticky maskable IRQ. Sits between the CPU SPI registers and the pads.
// PARAMETERS
//  DATA_WIDTH  32  max bits per frame; LEN_W = $clog2(DATA_WIDTH)
//  NUM_SS      4   number of slave-select outputs; SEL_W = max(1,$clog2(NUM_SS))
//  DIV_WIDTH   8   width of clk_div; SCK half-period H = clk_div+1 clk_cpu cycles
// PORTS
//  clk_cpu   in   1           system clock, all logic on rising edge
//  rst       in   1           synchronous, active-low reset
//  spi_on    in   1           core enable; 0 aborts any transfer
//  start     in   1           1-cycle request, accepted only in IDLE with spi_on=1
//  cpol      in   1           SCK idle level
//  cpha      in   1           0: sample leading edge, 1: sample trailing edge
//  lsb_first in   1           1: bit 0 first; 0: bit len first
//  len       in   LEN_W       frame length minus 1 (N = len+1 bits)
//  ss_sel    in   SEL_W       slave index to assert
//  clk_div   in   DIV_WIDTH   half-period divisor
//  tx_data   in   DATA_WIDTH  frame to send, right-justified in [len:0]
//  irq_en    in   1           IRQ mask
//  irq_clr   in   1           clears sticky irq
//  miso      in   1           serial input
//  sck       out  1           serial clock
//  mosi      out  1           serial output
//  ss_n      out  NUM_SS      active-low selects
//  busy      out  1           high in SETUP/SHIFT/HOLD/DONE
//  done      out  1           1-cycle pulse at end of frame
//  rx_data   out  DATA_WIDTH  received frame, right-justified, bits above len = 0
//  irq       out  1           sticky interrupt
// BEHAVIOUR
//  Reset (rst=0 at edge): state IDLE, sck=0, mosi=0, ss_n=all 1, busy=0, done=0, rx_data=0, irq=0, counters 0.
//  On accept, cpol/cpha/lsb_first/len/ss_sel/clk_div/tx_data latched; input changes mid-frame ignored.
//  FSM: IDLE -> SETUP (start&spi_on) -> SHIFT (after H cycles) -> HOLD (after 2N edges) -> DONE (after H) -> IDLE.
//  - IDLE: sck=latched cpol, ss_n all 1; start ignored if spi_on=0; start in any other state ignored.
//  - SETUP: ss_n[ss_sel]=0 from cycle after start; cpha=0 drives first bit on mosi on SETUP entry.
//  - SHIFT: sck toggles every H cycles, 2N toggles total. Leading edge: sample miso (cpha=0) / drive next
//    bit (cpha=1). Trailing edge: drive next bit (cpha=0) / sample miso (cpha=1). No drive after last bit.
//  - HOLD: sck at cpol, ss still low, H cycles; then ss_n all 1 at DONE entry.
//  - DONE: 1 cycle: done=1, rx_data updated (only here), irq set if irq_en.
//  Timing: start in cycle 0 -> ss_n low cycle 1 -> done in cycle 1+(2N+2)*H.
//  Bit order: MSB mode sends tx[len]..tx[0], first received bit lands in rx[len]; LSB mode sends tx[0]..tx[len],
//    first received bit lands in rx[0]. Bits above len on rx_data forced 0.
//  ss_sel >= NUM_SS: frame runs normally, no ss_n asserted.
//  spi_on=0 in any non-IDLE state: next cycle IDLE, ss_n all 1, sck=cpol, no done, rx_data and irq unchanged.
//  irq: set by DONE&irq_en, cleared by irq_clr; simultaneous set and clear -> set wins. irq_en=0 does not clear.
//  Divider counter reloads on every edge; clk_div=0 gives sck at clk_cpu/2.
// TESTING
//  T1 mode0 MSB, len=7, div=0, tx=0xA5, miso=mosi loopback -> rx_data=0x000000A5, done cycle 19, ss_n=4'b1110 (sel 0).
//  T2 mode3 LSB, len=15, div=3, ss_sel=2, slave model returns 0x1234 -> rx_data=0x1234, ss_n=4'b1011, sck idles 1.
//  T3 len=31 div=1 modes 1 and 2, tx=0xDEADBEEF loopback -> rx=0xDEADBEEF, 64 sck edges, done at 1+66*2=133.
//  T4 start pulsed during SHIFT and with spi_on=0 -> ignored, single done; drop spi_on mid-frame -> IDLE, no done.
//  T5 rst=0 mid-SHIFT -> next cycle all outputs at reset values; new frame after release completes correctly.
//  T6 irq_en=1 frame -> irq=1 until irq_clr; irq_clr in DONE cycle -> irq stays 1; irq_en=0 -> irq stays 0.

Source files
------------

// File: rtl/spi_master_core_mc.sv
// Multi-slave SPI master: programmable SCK divider, all CPOL/CPHA modes, 1..DATA_WIDTH bit frames,
// MSB/LSB first, one-hot-low slave selects and a sticky maskable interrupt.
module spi_master_core_mc #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SS     = 4,
   parameter int DIV_WIDTH  = 8,
   localparam int LEN_W     = $clog2(DATA_WIDTH),
   localparam int SEL_W     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
   input  logic                  clk_cpu,
   input  logic                  rst,
   input  logic                  spi_on,
   input  logic                  start,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic                  lsb_first,
   input  logic [LEN_W-1:0]      len,
   input  logic [SEL_W-1:0]      ss_sel,
   input  logic [DIV_WIDTH-1:0]  clk_div,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  irq_en,
   input  logic                  irq_clr,
   input  logic                  miso,
   output logic                  sck,
   output logic                  mosi,
   output logic [NUM_SS-1:0]     ss_n,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  irq
);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

   state_t                state;
   logic                  cpol_q, cpha_q, lsb_q;
   logic [LEN_W-1:0]      len_q;
   logic [DIV_WIDTH-1:0]  div_q, div_cnt;
   logic [DATA_WIDTH-1:0] tx_q, rx_sh;
   logic [LEN_W:0]        edge_cnt, tx_cnt, rx_cnt;
   logic                  tick, sample_edge, last_edge;

   // Frame bit k maps to bit position k (LSB first) or len-k (MSB first).
   function automatic logic [LEN_W-1:0] bit_pos(input logic lsb, input logic [LEN_W-1:0] n_m1,
                                                input logic [LEN_W:0] k);
      return lsb ? k[LEN_W-1:0] : n_m1 - k[LEN_W-1:0];
   endfunction

   function automatic logic [NUM_SS-1:0] ss_decode(input logic [SEL_W-1:0] sel);
      logic [NUM_SS-1:0] v;
      v = '1;
      for (int i = 0; i < NUM_SS; i++)
         if (int'(sel) == i) v[i] = 1'b0;
      return v;
   endfunction

   assign tick        = (div_cnt == div_q);
   // Even edge count = leading edge; cpha selects whether leading or trailing edges sample.
   assign sample_edge = ~edge_cnt[0] ^ cpha_q;
   assign last_edge   = (edge_cnt == {len_q, 1'b1});

   always_ff @(posedge clk_cpu) begin
      if (!rst) begin
         state    <= IDLE;
         sck      <= 1'b0;
         mosi     <= 1'b0;
         ss_n     <= '1;
         busy     <= 1'b0;
         done     <= 1'b0;
         rx_data  <= '0;
         irq      <= 1'b0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         lsb_q    <= 1'b0;
         len_q    <= '0;
         div_q    <= '0;
         tx_q     <= '0;
         rx_sh    <= '0;
         div_cnt  <= '0;
         edge_cnt <= '0;
         tx_cnt   <= '0;
         rx_cnt   <= '0;
      end else begin
         done <= 1'b0;
         // Setting in DONE takes priority over a simultaneous clear.
         if ((state == DONE) && irq_en && spi_on)
            irq <= 1'b1;
         else if (irq_clr)
            irq <= 1'b0;

         if ((state != IDLE) && !spi_on) begin
            state   <= IDLE;
            ss_n    <= '1;
            sck     <= cpol_q;
            busy    <= 1'b0;
            div_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  sck  <= cpol_q;
                  ss_n <= '1;
                  if (start && spi_on) begin
                     state    <= SETUP;
                     busy     <= 1'b1;
                     cpol_q   <= cpol;
                     cpha_q   <= cpha;
                     lsb_q    <= lsb_first;
                     len_q    <= len;
                     div_q    <= clk_div;
                     tx_q     <= tx_data;
                     sck      <= cpol;
                     ss_n     <= ss_decode(ss_sel);
                     div_cnt  <= '0;
                     edge_cnt <= '0;
                     rx_cnt   <= '0;
                     rx_sh    <= '0;
                     if (!cpha) begin
                        mosi   <= tx_data[bit_pos(lsb_first, len, '0)];
                        tx_cnt <= (LEN_W+1)'(1);
                     end else begin
                        tx_cnt <= '0;
                     end
                  end
               end
               SETUP: begin
                  if (tick) begin
                     div_cnt <= '0;
                     state   <= SHIFT;
                  end else begin
                     div_cnt <= div_cnt + 1'b1;
                  end
               end
               SHIFT: begin
                  if (tick) begin
                     div_cnt  <= '0;
                     sck      <= ~sck;
                     edge_cnt <= edge_cnt + 1'b1;
                     if (sample_edge) begin
                        rx_sh[bit_pos(lsb_q, len_q, rx_cnt)] <= miso;
                        rx_cnt <= rx_cnt + 1'b1;
                     end else if (tx_cnt <= {1'b0, len_q}) begin
                        mosi   <= tx_q[bit_pos(lsb_q, len_q, tx_cnt)];
                        tx_cnt <= tx_cnt + 1'b1;
                     end
                     if (last_edge) state <= HOLD;
                  end else begin
                     div_cnt <= div_cnt + 1'b1;
                  end
               end
               HOLD: begin
                  if (tick) begin
                     div_cnt <= '0;
                     state   <= DONE;
                     ss_n    <= '1;
                     done    <= 1'b1;
                     rx_data <= rx_sh;
                  end else begin
                     div_cnt <= div_cnt + 1'b1;
                  end
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_master_core_mc.sv
// Directed bench for spi_master_core_mc: loopback and slave-model frames, abort, reset and irq behaviour.
module tb_spi_master_core_mc;

   logic        clk_cpu = 1'b0;
   logic        rst = 1'b0, spi_on = 1'b0, start = 1'b0;
   logic        cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
   logic [4:0]  len = '0;
   logic [1:0]  ss_sel = '0;
   logic [7:0]  clk_div = '0;
   logic [31:0] tx_data = '0;
   logic        irq_en = 1'b0, irq_clr = 1'b0;
   logic        miso;
   logic        sck, mosi, busy, done, irq;
   logic [3:0]  ss_n;
   logic [31:0] rx_data;

   logic        loop_mode = 1'b1, slave_on = 1'b0, slave_miso = 1'b0;
   logic [15:0] slave_val = 16'h1234;
   int          slave_k = 0;
   int          n_chk = 0, n_pass = 0, n_fail = 0;
   int          cyc = 0, edges = 0, seen = 0;
   logic        prev_sck = 1'b0;
   logic [3:0]  ss_first = '0;

   spi_master_core_mc #(.DATA_WIDTH(32), .NUM_SS(4), .DIV_WIDTH(8)) dut (
      .clk_cpu(clk_cpu), .rst(rst), .spi_on(spi_on), .start(start), .cpol(cpol), .cpha(cpha),
      .lsb_first(lsb_first), .len(len), .ss_sel(ss_sel), .clk_div(clk_div), .tx_data(tx_data),
      .irq_en(irq_en), .irq_clr(irq_clr), .miso(miso), .sck(sck), .mosi(mosi), .ss_n(ss_n),
      .busy(busy), .done(done), .rx_data(rx_data), .irq(irq)
   );

   always #5 clk_cpu = ~clk_cpu;

   assign miso = loop_mode ? mosi : slave_miso;

   // Mode-3 slave on select 2: shifts out slave_val LSB first on each leading (falling) edge.
   always @(negedge sck) begin
      if (slave_on && !ss_n[2]) begin
         if (slave_k < 16) slave_miso = slave_val[slave_k];
         slave_k++;
      end
   end

   task automatic tick();
      @(posedge clk_cpu);
      #1;
      cyc++;
      if (sck !== prev_sck) edges++;
      prev_sck = sck;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic pol, input logic pha, input logic lsbf, input int ln,
                         input int sel, input int dv, input logic [31:0] tx);
      cpol = pol; cpha = pha; lsb_first = lsbf;
      len = 5'(ln); ss_sel = 2'(sel); clk_div = 8'(dv); tx_data = tx;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      edges = 0;
      prev_sck = sck;
      ss_first = ss_n;
   endtask

   task automatic wait_done(input int limit);
      while (done !== 1'b1 && cyc < limit) tick();
   endtask

   initial begin
      // Reset values
      repeat (3) tick();
      check("rst_sck", sck, 1'b0);
      check("rst_mosi", mosi, 1'b0);
      check("rst_ss_n", ss_n, 4'hF);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_rx", rx_data, 32'h0);
      check("rst_irq", irq, 1'b0);
      rst = 1'b1;
      spi_on = 1'b1;
      tick();

      // T1: mode 0, MSB, 8 bits, fastest SCK, loopback; upper tx bits must not leak
      launch(1'b0, 1'b0, 1'b0, 7, 0, 0, 32'hFFFF_FFA5);
      check("t1_ss_n", ss_first, 4'b1110);
      wait_done(100);
      check("t1_done_cyc", cyc, 19);
      check("t1_rx", rx_data, 32'h0000_00A5);
      check("t1_edges", edges, 16);
      check("t1_busy_done", busy, 1'b1);
      tick();
      check("t1_done_pulse", done, 1'b0);
      check("t1_busy_after", busy, 1'b0);
      check("t1_ss_after", ss_n, 4'hF);
      check("t1_irq_masked", irq, 1'b0);

      // T2: mode 3, LSB, 16 bits, div 3, slave 2 returns 0x1234
      loop_mode = 1'b0;
      slave_on = 1'b1;
      launch(1'b1, 1'b1, 1'b1, 15, 2, 3, 32'h0000_C3A5);
      check("t2_ss_n", ss_first, 4'b1011);
      wait_done(400);
      check("t2_done_cyc", cyc, 137);
      check("t2_rx", rx_data, 32'h0000_1234);
      check("t2_edges", edges, 32);
      tick();
      tick();
      check("t2_sck_idle", sck, 1'b1);
      slave_on = 1'b0;
      loop_mode = 1'b1;

      // T3: 32-bit frames, div 1, modes 1 and 2
      launch(1'b0, 1'b1, 1'b0, 31, 0, 1, 32'hDEAD_BEEF);
      wait_done(400);
      check("t3m1_done_cyc", cyc, 133);
      check("t3m1_rx", rx_data, 32'hDEAD_BEEF);
      check("t3m1_edges", edges, 64);
      tick();
      tick();
      launch(1'b1, 1'b0, 1'b1, 31, 1, 1, 32'hDEAD_BEEF);
      check("t3m2_ss_n", ss_first, 4'b1101);
      wait_done(400);
      check("t3m2_done_cyc", cyc, 133);
      check("t3m2_rx", rx_data, 32'hDEAD_BEEF);
      check("t3m2_edges", edges, 64);
      tick();
      tick();

      // T4a: start re-pulsed mid-frame with new config is ignored
      launch(1'b0, 1'b0, 1'b0, 7, 0, 0, 32'h0000_003C);
      repeat (4) tick();
      start = 1'b1; tx_data = 32'h0; len = 5'd3;
      tick();
      start = 1'b0;
      wait_done(100);
      check("t4_done_cyc", cyc, 19);
      check("t4_rx", rx_data, 32'h0000_003C);
      seen = 0;
      repeat (30) begin tick(); if (done === 1'b1) seen++; end
      check("t4_single_done", seen, 0);

      // T4b: start with spi_on=0 is ignored
      spi_on = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t4_off_busy", busy, 1'b0);
      check("t4_off_ss_n", ss_n, 4'hF);
      seen = 0;
      repeat (20) begin tick(); if (done === 1'b1) seen++; end
      check("t4_off_no_done", seen, 0);
      spi_on = 1'b1;

      // T4c: dropping spi_on mid-frame aborts to IDLE
      launch(1'b1, 1'b0, 1'b0, 7, 1, 1, 32'h0000_000F);
      repeat (5) tick();
      spi_on = 1'b0;
      tick();
      check("t4_abort_busy", busy, 1'b0);
      check("t4_abort_ss_n", ss_n, 4'hF);
      check("t4_abort_sck", sck, 1'b1);
      spi_on = 1'b1;
      seen = 0;
      repeat (40) begin tick(); if (done === 1'b1) seen++; end
      check("t4_abort_no_done", seen, 0);
      check("t4_abort_rx_kept", rx_data, 32'h0000_003C);

      // T6: sticky irq, mask, and set-beats-clear
      irq_en = 1'b1;
      launch(1'b0, 1'b0, 1'b0, 7, 0, 0, 32'h0000_0011);
      wait_done(100);
      check("t6_rx", rx_data, 32'h0000_0011);
      tick();
      check("t6_irq_set", irq, 1'b1);
      irq_en = 1'b0;
      repeat (3) tick();
      check("t6_irq_sticky", irq, 1'b1);
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
      check("t6_irq_clr", irq, 1'b0);
      launch(1'b0, 1'b0, 1'b0, 7, 0, 0, 32'h0000_0022);
      wait_done(100);
      tick();
      check("t6_irq_masked", irq, 1'b0);
      irq_en = 1'b1;
      launch(1'b0, 1'b0, 1'b0, 7, 0, 0, 32'h0000_0033);
      wait_done(100);
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
      check("t6_set_wins", irq, 1'b1);
      irq_en = 1'b0;
      tick();

      // T5: reset mid-SHIFT, then a clean frame
      launch(1'b1, 1'b0, 1'b0, 7, 0, 1, 32'h0000_00FF);
      repeat (6) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("t5_sck", sck, 1'b0);
      check("t5_mosi", mosi, 1'b0);
      check("t5_ss_n", ss_n, 4'hF);
      check("t5_busy", busy, 1'b0);
      check("t5_done", done, 1'b0);
      check("t5_rx", rx_data, 32'h0);
      check("t5_irq", irq, 1'b0);
      tick();
      launch(1'b0, 1'b0, 1'b0, 7, 3, 0, 32'h0000_0096);
      check("t5_new_ss_n", ss_first, 4'b0111);
      wait_done(100);
      check("t5_new_done_cyc", cyc, 19);
      check("t5_new_rx", rx_data, 32'h0000_0096);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
